mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 data multiplexer among four requesters and presents the winner's word on a single registered valid/ready output port. It generates the 2-bit mux select, a one-hot grant back to the requesters, and a one-entry output register that absorbs downstream back-pressure. It sits between four producer blocks and one shared consumer in the lab datapath.

## Interface
- WIDTH, 8, data width of each requester word and of the output word
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  request per requester; bit i held high while requester i has a word pending
- data0..data3  input  WIDTH each  requester words, valid while the matching req bit is high
- gnt  output  4  one-hot grant; bit i high for the single cycle in which requester i's word is captured
- s  output  2  mux select of the current winner (combinational, valid when gnt != 0)
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered winning word
- out_src  output  2  index of the requester that produced out_data
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Clocking and reset are fixed: one clock, clk; reset rst is asynchronous and active-high.
- Output slot is free when out_valid = 0 or out_ready = 1 (load-while-unload allowed).
- When slot free and req != 0: winner = first set req bit searching from (ptr+1) mod 4 upward, wrapping 3 -> 0; s = winner; gnt = one-hot(winner); next edge loads out_data = data[winner], out_src = winner, out_valid = 1, ptr = winner.
- When slot free and req = 0: gnt = 0, s = ptr, next edge clears out_valid if it was consumed; ptr unchanged; out_data/out_src keep last value.
- When slot not free (out_valid = 1, out_ready = 0): gnt = 0, out_* hold, ptr holds; requests wait.
- Requester rule: after seeing gnt[i] high at an edge, requester i either drops req[i] or presents its next word; arbiter never grants the same requester twice while others are pending.
- Reset values: out_valid 0, out_data 0, out_src 0, gnt 0, ptr 3 (requester 0 has first priority), s 0.

## Timing
- gnt and s combinational from req, ptr, out_valid, out_ready; no combinational path from data to any output.
- Latency: req sampled in cycle N -> out_valid high from edge ending cycle N.
- Throughput: one word per cycle with out_ready held high and requests pending.
- Stall: out_ready low freezes out_data and out_src indefinitely; no word lost or duplicated.
- Wrap-around: ptr = 3 with req = 4'b1001 -> requester 0 wins; ptr = 0 next -> requester 3 wins.
- rst asserted mid-transfer: out_valid and gnt drop immediately (asynchronously); pending word discarded; ptr back to 3.
- req changes while slot busy have no effect until slot frees.

## Structure
- Shared package: NUM_REQ = 4, SEL_W = 2, reset pointer value PTR_RST = 2'd3.
- One sub-module: mux4_w, a WIDTH-parameterised 4:1 combinational mux (inputs a..d, select s, output y); the arbiter instantiates it once, driven by s.
- Arbiter core: rotate-priority encoder, ptr register, output register slice; no other state.

## Test plan
- Reset: rst high mid-cycle with out_valid = 1 -> out_valid, gnt drop at once; after release req = 4'b1111 -> first gnt = 4'b0001, out_src = 0.
- Fairness: req = 4'b1111 held, out_ready = 1, data0..3 = 8'hA0..8'hA3 -> out_data sequence A0, A1, A2, A3, A0, one per cycle.
- Sparse/wrap: ptr = 3 state, req = 4'b1001 -> grant order 0, 3, 0, 3; req = 4'b0100 only -> gnt = 4'b0100 every free cycle.
- Back-pressure: out_ready low 5 cycles with out_data = 8'h55 -> out_data stays 55, gnt = 0 throughout; out_ready high -> next winner loaded same edge.
- Idle: req = 0 with out_ready = 1 -> out_valid falls after last word consumed, ptr unchanged, next single request granted in one cycle.
- Simultaneous: out_valid = 1, out_ready = 1, req = 4'b0010 same cycle -> gnt = 4'b0010 and new word loaded with no bubble.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg: shared constants and rotate-priority helper for the round-robin arbiter
package mux4_rr_arbiter_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W = 2;
    localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

    // Scan from the top candidate (ptr itself) down to ptr+1 so the last hit is the highest priority.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [SEL_W-1:0] p);
        logic [SEL_W-1:0] w;
        logic [SEL_W-1:0] idx;
        w = p;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = p + SEL_W'(k);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction
endpackage

// File: rtl/mux4_rr_arbiter_mux4.sv
// mux4_w: WIDTH-bit 4:1 combinational multiplexer
module mux4_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);
    always_comb y = s[1] ? (s[0] ? d : c) : (s[0] ? b : a);
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter over a shared 4:1 mux with a registered valid/ready output slot
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   data0,
    input  logic [WIDTH-1:0]   data1,
    input  logic [WIDTH-1:0]   data2,
    input  logic [WIDTH-1:0]   data3,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   s,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src,
    input  logic               out_ready
);
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pick;
    logic [WIDTH-1:0] mux_y;
    logic             free;
    logic             take;

    assign free = !out_valid || out_ready;
    assign pick = rr_pick(req, ptr);
    // Gating with rst makes gnt and s drop the instant reset asserts, not at the next edge.
    assign take = !rst && free && |req;
    assign s    = rst ? '0 : (take ? pick : ptr);
    assign gnt  = take ? NUM_REQ'(1) << pick : '0;

    mux4_w #(.WIDTH(WIDTH)) u_mux (
        .a(data0),
        .b(data1),
        .c(data2),
        .d(data3),
        .s(s),
        .y(mux_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= PTR_RST;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= mux_y;
            out_src   <= pick;
            ptr       <= pick;
        end else if (free) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] data0, data1, data2, data3;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_src;
    logic       out_ready;
    int n_cmp = 0;
    int n_err = 0;

    mux4_rr_arbiter #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .data0(data0),
        .data1(data1),
        .data2(data2),
        .data3(data3),
        .gnt(gnt),
        .s(s),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_src(out_src),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        out_ready = 1'b0;
        data0 = 8'hA0;
        data1 = 8'hA1;
        data2 = 8'hA2;
        data3 = 8'hA3;
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'h00);
        chk("rst_src", 32'(out_src), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        rst = 1'b0;
        req = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("first_s", 32'(s), 32'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("fair_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
            step();
            chk("fair_valid", 32'(out_valid), 32'd1);
            chk("fair_data", 32'(out_data), 32'(8'hA0 + (i % 4)));
        end
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_gnt", 32'(gnt), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_gnt", 32'(gnt), 32'b0001);
        step();
        chk("post_rst_src", 32'(out_src), 32'd0);
        req = 4'b1000;
        #1;
        chk("to_ptr3_gnt", 32'(gnt), 32'b1000);
        step();
        req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wrap_gnt", 32'(gnt), (i % 2 == 0) ? 32'b0001 : 32'b1000);
            step();
            chk("wrap_src", 32'(out_src), (i % 2 == 0) ? 32'd0 : 32'd3);
        end
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("solo_gnt", 32'(gnt), 32'b0100);
            step();
            chk("solo_src", 32'(out_src), 32'd2);
        end
        data2 = 8'h55;
        step();
        chk("bp_load", 32'(out_data), 32'h55);
        out_ready = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_gnt", 32'(gnt), 32'd0);
            step();
            chk("bp_data", 32'(out_data), 32'h55);
            chk("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_gnt", 32'(gnt), 32'b1000);
        step();
        chk("bp_rel_data", 32'(out_data), 32'hA3);
        chk("bp_rel_src", 32'(out_src), 32'd3);
        req = 4'b0000;
        #1;
        chk("idle_gnt", 32'(gnt), 32'd0);
        chk("idle_s", 32'(s), 32'd3);
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);
        step();
        chk("idle_hold_src", 32'(out_src), 32'd3);
        chk("idle_hold_data", 32'(out_data), 32'hA3);
        chk("idle_s2", 32'(s), 32'd3);
        req = 4'b0001;
        #1;
        chk("idle_req_gnt", 32'(gnt), 32'b0001);
        step();
        chk("idle_req_valid", 32'(out_valid), 32'd1);
        chk("idle_req_src", 32'(out_src), 32'd0);
        req = 4'b0010;
        #1;
        chk("simul_gnt", 32'(gnt), 32'b0010);
        chk("simul_s", 32'(s), 32'd1);
        step();
        chk("simul_valid", 32'(out_valid), 32'd1);
        chk("simul_data", 32'(out_data), 32'hA1);
        req = 4'b0000;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
